mem_unit: RTL and testbench
===========================

Name: mem_unit

Overview:
Parametrised memory subsystem for the hmmm core. It merges the address register, data register and RAM into one block with configurable width and depth. It adds a registered read handshake and an internal ready/valid streaming program loader that replaces the external address/data load pins. The block sits on the shared 16-bit core bus; its drive request is resolved to tri-state at the top level.

Parameters:
DATA_W, 16, word width of bus and RAM
ADDR_W, 8, MAR width
DEPTH, 256, number of RAM words; must satisfy DEPTH <= 2**ADDR_W
CNT_W, 9, width of load_count; must satisfy 2**CNT_W > DEPTH

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
bus_in  in  DATA_W  current value of shared bus
bus_out  out  DATA_W  MDR contents presented to bus
bus_oe  out  1  request to drive bus_out onto bus
mar_in  in  1  latch bus_in[ADDR_W-1:0] into MAR
mar_inc  in  1  MAR <= MAR+1 (wraps at 2**ADDR_W)
mdr_in  in  1  write bus_in to RAM[MAR] and to MDR
mdr_out  in  1  read request, level, held until rd_valid seen
rd_valid  out  1  MDR holds RAM[MAR] and is on bus
busy  out  1  block is in RD or LOAD
pgrm_en  in  1  loader enable, level
pgrm_valid  in  1  loader word valid
pgrm_data  in  DATA_W  loader word
pgrm_ready  out  1  loader accepts word this cycle
load_count  out  CNT_W  words written in current or last load
overflow  out  1  sticky: load word offered at ptr == DEPTH
addr_err  out  1  sticky: core access with MAR >= DEPTH

Behaviour:
- Reset values: MAR=0, MDR=0, state IDLE, bus_oe=0, rd_valid=0, busy=0, pgrm_ready=0, load_count=0, overflow=0, addr_err=0. RAM contents are NOT cleared.
- States: IDLE, RD, VALID, LOAD.
- IDLE:
  - mar_in: MAR <= bus_in[ADDR_W-1:0]. If both mar_in and mar_inc are set, mar_in wins.
  - mdr_in: RAM[MAR] <= bus_in and MDR <= bus_in, using the pre-edge MAR when mar_in is asserted in the same cycle.
  - mdr_out with mdr_in low: go to RD.
  - mdr_in and mdr_out together: write wins and the read is ignored that cycle.
- RD: one cycle. MDR <= RAM[MAR], or 0 if MAR >= DEPTH. busy=1. Core control inputs are ignored. Next state VALID.
- VALID: bus_oe=1, rd_valid=1, bus_out=MDR. Stays in VALID while mdr_out=1; mdr_out=0 returns to IDLE, with bus_oe low in that same cycle. Read latency: assert mdr_out in cycle N, data on the bus in cycle N+2.
- MAR >= DEPTH on a write or read: the write is dropped, the read returns 0, addr_err is set and stays set until rst.
- LOAD entry: a rising edge of pgrm_en, detected from a registered copy, enters LOAD from any state. An in-progress RD/VALID is aborted and bus_oe drops the next cycle. On entry: ptr=0, load_count=0, overflow=0.
- LOAD:
  - busy=1; core control inputs are ignored.
  - pgrm_ready = (ptr < DEPTH).
  - pgrm_valid && pgrm_ready: RAM[ptr] <= pgrm_data, ptr++, load_count++.
  - pgrm_valid while ptr == DEPTH: word dropped, overflow set.
  - pgrm_en low: IDLE next cycle, pgrm_ready=0, MAR=0. load_count holds its value until the next LOAD entry or rst.
- rst has priority over every input. Asserting it mid-read or mid-load returns to IDLE with the reset values above. Words already loaded remain in RAM.
- bus_oe is never asserted outside VALID.

Test Plan:
- Write/read: mar_in bus_in=0x0005; mdr_in bus_in=0xBEEF; mdr_out held -> rd_valid and bus_oe rise 2 cycles later, bus_out=0xBEEF; drop mdr_out -> bus_oe=0 the same cycle.
- Same-cycle mar_in+mdr_in: MAR=3, then bus_in=0x0007 with both asserted -> RAM[3]=0x0007, MAR=7. mar_inc at MAR=0xFF -> MAR=0x00.
- Load stream: pgrm_en=1, 4 valid words 0x1111..0x4444 with a 1-cycle valid gap -> RAM[0..3] match, load_count=4, pgrm_en=0 -> IDLE, MAR=0, reading addr 2 gives 0x3333.
- Overflow with DEPTH=4: 5 valid words -> pgrm_ready=0 after the 4th, overflow=1, RAM[0..3] hold only the first 4 words.
- Out of range with DEPTH=200: MAR=250, mdr_in then mdr_out -> addr_err=1, read returns 0x0000, no RAM location is modified.
- Reset mid-operation: rst in RD -> bus_oe never asserts, all outputs at reset values. rst mid-load after 2 words -> RAM[0..1] retained, load_count=0.

Source files
------------

// File: rtl/mem_unit.sv
// Memory subsystem for the hmmm core: MAR, MDR and RAM, a registered read handshake
// and a ready/valid program loader that streams words into RAM from address 0.
module mem_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              mar_in,
  input  logic              mar_inc,
  input  logic              mdr_in,
  input  logic              mdr_out,
  output logic              rd_valid,
  output logic              busy,
  input  logic              pgrm_en,
  input  logic              pgrm_valid,
  input  logic [DATA_W-1:0] pgrm_data,
  output logic              pgrm_ready,
  output logic [CNT_W-1:0]  load_count,
  output logic              overflow,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshakes:
  //  core read : mdr_out is a level held by the core; rd_valid marks MDR == RAM[MAR],
  //              and the core releases mdr_out once it has seen rd_valid.
  //  loader    : a word transfers on every cycle where pgrm_valid && pgrm_ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_VALID = 2'd2,
    S_LOAD  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  mar_q, mar_d;
  logic [DATA_W-1:0]  mdr_q, mdr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               aerr_q, aerr_d;
  logic               pgrm_en_q;

  logic               pgrm_rise;
  logic               mar_ok;
  logic               load_room;

  logic [DATA_W-1:0]  ram [DEPTH];
  logic               ram_we;
  logic [IDX_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;

  assign pgrm_rise = pgrm_en && !pgrm_en_q;
  assign mar_ok    = (int'(mar_q) < DEPTH);
  assign load_room = (int'(cnt_q) < DEPTH);
  assign ram_rdata = ram[mar_q[IDX_W-1:0]];

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      aerr_q  <= aerr_d;
    end
  end

  // Tracks pgrm_en even through reset so a level held across rst does not re-enter LOAD.
  always_ff @(posedge clk) begin
    pgrm_en_q <= pgrm_en;
  end

  // RAM contents survive reset; only the write strobe is blocked while rst is high.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (pgrm_rise) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mdr_out && !mdr_in) state_d = S_RD;
        end
        S_RD: begin
          state_d = S_VALID;
        end
        S_VALID: begin
          if (!mdr_out) state_d = S_IDLE;
        end
        S_LOAD: begin
          if (!pgrm_en) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values and RAM write port
  always_comb begin
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    aerr_d    = aerr_q;
    ram_we    = 1'b0;
    ram_waddr = mar_q[IDX_W-1:0];
    ram_wdata = bus_in;
    if (pgrm_rise) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mar_in) begin
            mar_d = bus_in[ADDR_W-1:0];
          end else if (mar_inc) begin
            mar_d = mar_q + ADDR_W'(1);
          end
          // The write uses the pre-edge MAR even when mar_in is also set.
          if (mdr_in) begin
            mdr_d = bus_in;
            if (mar_ok) ram_we = 1'b1;
            else        aerr_d = 1'b1;
          end
        end
        S_RD: begin
          mdr_d = mar_ok ? ram_rdata : '0;
          if (!mar_ok) aerr_d = 1'b1;
        end
        S_LOAD: begin
          if (!pgrm_en) begin
            mar_d = '0;
          end else if (pgrm_valid) begin
            if (load_room) begin
              ram_we    = 1'b1;
              ram_waddr = cnt_q[IDX_W-1:0];
              ram_wdata = pgrm_data;
              cnt_d     = cnt_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus_out    = mdr_q;
    bus_oe     = (state_q == S_VALID) && mdr_out;
    rd_valid   = (state_q == S_VALID);
    busy       = (state_q == S_RD) || (state_q == S_LOAD);
    pgrm_ready = (state_q == S_LOAD) && pgrm_en && load_room;
    load_count = cnt_q;
    overflow   = ovf_q;
    addr_err   = aerr_q;
  end

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit (DEPTH=200): directed steps plus random traffic, compared against
// an array-based model of RAM, MAR and the loader counters.
module tb_mem_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int CNT_W  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              mar_in, mar_inc, mdr_in, mdr_out;
  logic              rd_valid, busy;
  logic              pgrm_en, pgrm_valid;
  logic [DATA_W-1:0] pgrm_data;
  logic              pgrm_ready;
  logic [CNT_W-1:0]  load_count;
  logic              overflow, addr_err;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [DATA_W-1:0] m_mem [256];
  bit                m_def [256];
  int                m_mar;
  bit                m_aerr;
  bit                m_ovf;
  int                m_cnt;
  logic [DATA_W-1:0] words_q [$];

  mem_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .mar_in(mar_in), .mar_inc(mar_inc), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .rd_valid(rd_valid), .busy(busy), .pgrm_en(pgrm_en), .pgrm_valid(pgrm_valid),
    .pgrm_data(pgrm_data), .pgrm_ready(pgrm_ready), .load_count(load_count),
    .overflow(overflow), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_bus_oe"}, bus_oe, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pgrm_ready"}, pgrm_ready, 0);
    check({tag, "_load_count"}, load_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_addr_err"}, addr_err, 0);
    check({tag, "_bus_out"}, bus_out, 0);
  endtask

  task automatic set_mar(input int a);
    mar_in = 1'b1;
    bus_in = DATA_W'(a);
    tick();
    mar_in = 1'b0;
    m_mar  = a % 256;
  endtask

  task automatic write_at(input int a, input logic [DATA_W-1:0] d);
    set_mar(a);
    mdr_in = 1'b1;
    bus_in = d;
    tick();
    mdr_in = 1'b0;
    if (m_mar < DEPTH) begin
      m_mem[m_mar] = d;
      m_def[m_mar] = 1'b1;
    end else begin
      m_aerr = 1'b1;
    end
  endtask

  // Read at the current MAR and follow the full handshake.
  task automatic read_cur(input string tag);
    logic [DATA_W-1:0] exp;
    int hold;
    exp = (m_mar < DEPTH) ? m_mem[m_mar] : '0;
    if (m_mar >= DEPTH) m_aerr = 1'b1;
    mdr_out = 1'b1;
    #1;
    check({tag, "_oe_req"}, bus_oe, 0);
    tick();
    check({tag, "_rd_busy"}, busy, 1);
    check({tag, "_rd_oe"}, bus_oe, 0);
    tick();
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_oe"}, bus_oe, 1);
    check({tag, "_data"}, bus_out, exp);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold"}, bus_out, exp);
    end
    mdr_out = 1'b0;
    #1;
    check({tag, "_oe_drop"}, bus_oe, 0);
    tick();
    check({tag, "_valid_drop"}, rd_valid, 0);
    check({tag, "_aerr"}, addr_err, m_aerr);
  endtask

  // Offer n words from words_q (random data if empty); alt forces a 1-cycle valid gap.
  task automatic do_load(input string tag, input int n, input bit alt);
    int offered = 0;
    int cyc = 0;
    pgrm_en = 1'b1;
    tick();
    m_cnt = 0;
    m_ovf = 1'b0;
    while (offered < n) begin
      pgrm_valid = alt ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      pgrm_data  = (words_q.size() > 0) ? words_q[0] : DATA_W'($urandom);
      #1;
      check({tag, "_ready"}, pgrm_ready, (m_cnt < DEPTH));
      check({tag, "_count"}, load_count, m_cnt);
      check({tag, "_ovf"}, overflow, m_ovf);
      check({tag, "_busy"}, busy, 1);
      if (pgrm_valid) begin
        offered++;
        if (words_q.size() > 0) void'(words_q.pop_front());
        if (m_cnt < DEPTH) begin
          m_mem[m_cnt] = pgrm_data;
          m_def[m_cnt] = 1'b1;
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    pgrm_valid = 1'b0;
    pgrm_en    = 1'b0;
    #1;
    check({tag, "_exit_ready"}, pgrm_ready, 0);
    tick();
    m_mar = 0;
    check({tag, "_exit_busy"}, busy, 0);
    check({tag, "_final_count"}, load_count, m_cnt);
    check({tag, "_final_ovf"}, overflow, m_ovf);
  endtask

  initial begin
    logic [DATA_W-1:0] w0, w1;
    int a;
    rst = 1'b1; bus_in = '0; mar_in = 0; mar_inc = 0; mdr_in = 0; mdr_out = 0;
    pgrm_en = 0; pgrm_valid = 0; pgrm_data = '0;
    for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_def[i] = 1'b0; end
    m_mar = 0; m_aerr = 0; m_ovf = 0; m_cnt = 0;

    // Reset state
    tick(); tick();
    check_reset_outs("reset");
    rst = 1'b0;
    tick();
    check_reset_outs("post_reset");

    // Basic write/read
    write_at(5, 16'hBEEF);
    read_cur("rd5");

    // mar_in and mdr_in in the same cycle: write uses the old MAR
    write_at(7, 16'hA5A5);
    set_mar(3);
    mar_in = 1'b1; mdr_in = 1'b1; bus_in = 16'h0007;
    tick();
    mar_in = 1'b0; mdr_in = 1'b0;
    m_mem[3] = 16'h0007; m_def[3] = 1'b1; m_mar = 7;
    read_cur("combo_mar7");
    set_mar(3);
    read_cur("combo_ram3");

    // Directed load with a 1-cycle gap between words
    words_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_load("load4", 4, 1'b1);
    check("load4_count", load_count, 4);
    mar_inc = 1'b1; tick(); tick(); mar_inc = 1'b0;
    m_mar = 2;
    read_cur("load4_rd2");

    // MAR wrap and mar_in priority over mar_inc
    set_mar(8'hFF);
    mar_inc = 1'b1; tick(); mar_inc = 1'b0;
    m_mar = 0;
    read_cur("wrap_rd0");
    write_at(16, 16'h1616);
    mar_in = 1'b1; mar_inc = 1'b1; bus_in = 16'h0005;
    tick();
    mar_in = 1'b0; mar_inc = 1'b0;
    m_mar = 5;
    read_cur("marin_wins");

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 0 || !m_def[a]) begin
        write_at(a, DATA_W'($urandom));
      end else begin
        set_mar(a);
        read_cur("rand_rd");
      end
    end

    // Out-of-range access
    check("aerr_before", addr_err, 0);
    write_at(250, 16'hDEAD);
    check("aerr_write", addr_err, 1);
    read_cur("oor_rd");
    set_mar(50);
    if (m_def[50]) read_cur("oor_alias50");

    // Overflow: offer more words than DEPTH
    words_q.delete();
    do_load("ovf", DEPTH + 3, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_count", load_count, DEPTH);
    set_mar(DEPTH - 1);
    read_cur("ovf_last");
    do_load("reload", 3, 1'b0);
    check("reload_ovf_clear", overflow, 0);

    // Reset during RD
    set_mar(1);
    mdr_out = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check("rstrd_oe_before", bus_oe, 0);
    tick();
    rst = 1'b0; mdr_out = 1'b0;
    m_mar = 0; m_aerr = 0; m_ovf = 0; m_cnt = 0;
    #1;
    check_reset_outs("rstrd");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstrd_oe_idle", bus_oe, 0);
      check("rstrd_valid_idle", rd_valid, 0);
    end

    // Reset during LOAD after two words; a word offered during rst is not written
    w0 = DATA_W'($urandom);
    w1 = DATA_W'($urandom);
    pgrm_en = 1'b1;
    tick();
    pgrm_valid = 1'b1; pgrm_data = w0;
    #1; check("rstld_ready0", pgrm_ready, 1);
    tick();
    pgrm_data = w1;
    tick();
    check("rstld_count2", load_count, 2);
    m_mem[0] = w0; m_mem[1] = w1; m_def[0] = 1'b1; m_def[1] = 1'b1;
    rst = 1'b1; pgrm_en = 1'b0; pgrm_data = ~m_mem[2];
    tick();
    rst = 1'b0; pgrm_valid = 1'b0;
    m_mar = 0;
    #1;
    check_reset_outs("rstld");
    set_mar(0); read_cur("rstld_rd0");
    set_mar(1); read_cur("rstld_rd1");
    set_mar(2); read_cur("rstld_rd2");

    // Full sweep of every location the model knows
    for (int i = 0; i < DEPTH; i++) begin
      if (m_def[i]) begin
        set_mar(i);
        read_cur("sweep");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
